// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined RV32 control unit.
// Ports: none (ALU codes, opcodes, regsel, stall states, EX/WB bundles).
package ctrl_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_XOR   = 4'b0010;
   localparam logic [3:0] ALU_ADD   = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0100;
   localparam logic [3:0] ALU_MUL   = 4'b0101;
   localparam logic [3:0] ALU_MULH  = 4'b0110;
   localparam logic [3:0] ALU_MULHU = 4'b0111;
   localparam logic [3:0] ALU_SLL   = 4'b1000;
   localparam logic [3:0] ALU_SRL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_SLT   = 4'b1100;
   localparam logic [3:0] ALU_SLTU  = 4'b1101;

   localparam logic [6:0] OP_R   = 7'h33;
   localparam logic [6:0] OP_I   = 7'h13;
   localparam logic [6:0] OP_LUI = 7'h37;
   localparam logic [6:0] OP_SYS = 7'h73;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      RS_GPIO = 2'b00,
      RS_UIMM = 2'b01,
      RS_ALU  = 2'b10
   } regsel_e;

   typedef enum logic {
      S_RUN,
      S_MSTALL
   } mstate_e;

   typedef struct packed {
      logic        regwrite;
      logic [4:0]  rd;
      regsel_e     regsel;
      logic [31:0] imm;
   } wb_ctrl_t;

   typedef struct packed {
      logic [3:0]  aluop;
      logic        alusrc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      wb_ctrl_t    wb;
   } ex_ctrl_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: inst -> EX bundle, GPIO strobe, illegal.
// Ports: i_inst in; o_ex, o_use_rs2, o_gpio_we, o_gpio_sel, o_illegal out.
module ctrl_decode import ctrl_pkg::*; #(
   parameter int               N_GPIO        = 2,
   parameter logic [11:0]      CSR_BASE      = 12'hF00,
   parameter logic [N_GPIO-1:0] GPIO_OUT_MASK = 2'b01,
   parameter int               GSEL_W        = 1
) (
   input  logic [31:0]       i_inst,
   output ex_ctrl_t          o_ex,
   output logic              o_use_rs2,
   output logic [N_GPIO-1:0] o_gpio_we,
   output logic [GSEL_W-1:0] o_gpio_sel,
   output logic              o_illegal
);

   logic [6:0]  w_op;
   logic [4:0]  w_rd;
   logic [2:0]  w_f3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [6:0]  w_f7;
   logic [11:0] w_csr;
   logic        w_hit;
   logic        w_out;
   logic        w_ill;

   assign w_op  = i_inst[6:0];
   assign w_rd  = i_inst[11:7];
   assign w_f3  = i_inst[14:12];
   assign w_rs1 = i_inst[19:15];
   assign w_rs2 = i_inst[24:20];
   assign w_f7  = i_inst[31:25];
   assign w_csr = i_inst[31:20];

   always_comb begin
      o_ex       = '0;
      o_use_rs2  = 1'b0;
      o_gpio_we  = '0;
      o_gpio_sel = '0;
      o_illegal  = 1'b0;
      w_hit      = 1'b0;
      w_out      = 1'b0;
      w_ill      = 1'b0;
      o_ex.rs1   = w_rs1;
      o_ex.rs2   = w_rs2;
      o_ex.wb.rd = w_rd;
      unique case (1'b1)
         (w_op == OP_R): begin
            o_use_rs2         = 1'b1;
            o_ex.wb.regwrite  = 1'b1;
            o_ex.wb.regsel    = RS_ALU;
            unique case ({w_f7, w_f3})
               {7'h00, 3'b000}: o_ex.aluop = ALU_ADD;
               {7'h00, 3'b111}: o_ex.aluop = ALU_AND;
               {7'h00, 3'b110}: o_ex.aluop = ALU_OR;
               {7'h00, 3'b100}: o_ex.aluop = ALU_XOR;
               {7'h00, 3'b001}: o_ex.aluop = ALU_SLL;
               {7'h00, 3'b101}: o_ex.aluop = ALU_SRL;
               {7'h00, 3'b010}: o_ex.aluop = ALU_SLT;
               {7'h00, 3'b011}: o_ex.aluop = ALU_SLTU;
               {7'h20, 3'b000}: o_ex.aluop = ALU_SUB;
               {7'h20, 3'b101}: o_ex.aluop = ALU_SRA;
               {7'h01, 3'b000}: o_ex.aluop = ALU_MUL;
               {7'h01, 3'b001}: o_ex.aluop = ALU_MULH;
               {7'h01, 3'b011}: o_ex.aluop = ALU_MULHU;
               default:         w_ill       = 1'b1;
            endcase
         end
         (w_op == OP_I): begin
            o_ex.alusrc      = 1'b1;
            o_ex.wb.regwrite = 1'b1;
            o_ex.wb.regsel   = RS_ALU;
            o_ex.imm         = {{20{i_inst[31]}}, i_inst[31:20]};
            unique case (w_f3)
               3'b000: o_ex.aluop = ALU_ADD;
               3'b111: o_ex.aluop = ALU_AND;
               3'b100: o_ex.aluop = ALU_XOR;
               3'b001: begin
                  o_ex.imm   = {27'd0, w_rs2};
                  o_ex.aluop = ALU_SLL;
                  w_ill      = (w_f7 != 7'h00);
               end
               3'b101: begin
                  o_ex.imm = {27'd0, w_rs2};
                  if (w_f7 == 7'h00)
                     o_ex.aluop = ALU_SRL;
                  else if (w_f7 == 7'h20)
                     o_ex.aluop = ALU_SRA;
                  else
                     w_ill = 1'b1;
               end
               default: w_ill = 1'b1;
            endcase
         end
         (w_op == OP_LUI): begin
            o_ex.aluop       = ALU_ADD;
            o_ex.alusrc      = 1'b1;
            o_ex.imm         = {i_inst[31:12], 12'd0};
            o_ex.wb.imm      = {i_inst[31:12], 12'd0};
            o_ex.wb.regwrite = 1'b1;
            o_ex.wb.regsel   = RS_UIMM;
         end
         (w_op == OP_SYS): begin
            for (int i = 0; i < N_GPIO; i++) begin
               if (w_csr == CSR_BASE + 12'(i)) begin
                  w_hit        = 1'b1;
                  w_out        = GPIO_OUT_MASK[i];
                  o_gpio_sel   = GSEL_W'(i);
                  o_gpio_we[i] = GPIO_OUT_MASK[i];
               end
            end
            o_ex.wb.regsel   = RS_GPIO;
            o_ex.wb.regwrite = !w_out;
            w_ill            = (w_f3 != 3'b001) || !w_hit;
         end
         default: w_ill = 1'b1;
      endcase
      // x0 never gets written; the GPIO strobe is independent of rd
      if (w_rd == 5'd0)
         o_ex.wb.regwrite = 1'b0;
      if (w_ill) begin
         o_ex       = '0;
         o_use_rs2  = 1'b0;
         o_gpio_we  = '0;
         o_gpio_sel = '0;
      end
      o_illegal = w_ill;
   end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered RV32 control unit: EX/WB control registers, mul stall, fwd.
// Ports: clk, rst_n, inst_valid/inst/inst_ready, ex_* , wb_*, illegal(_clr).
module control_unit_pipe import ctrl_pkg::*; #(
   parameter int                N_GPIO        = 2,
   parameter logic [11:0]       CSR_BASE      = 12'hF00,
   parameter logic [N_GPIO-1:0] GPIO_OUT_MASK = 2'b01,
   parameter int                MUL_LATENCY   = 1,
   localparam int               GSEL_W = (N_GPIO > 1) ? $clog2(N_GPIO) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_valid,
   input  logic [31:0]       inst,
   output logic              inst_ready,
   output logic              ex_valid,
   output logic [3:0]        ex_aluop,
   output logic              ex_alusrc,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic              ex_fwd_a,
   output logic              ex_fwd_b,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [4:0]        wb_rd,
   output logic [1:0]        wb_regsel,
   output logic [N_GPIO-1:0] wb_gpio_we,
   output logic [GSEL_W-1:0] wb_gpio_sel,
   output logic [31:0]       wb_imm,
   output logic              illegal,
   input  logic              illegal_clr
);

   ex_ctrl_t          w_dec;
   logic              w_dec_rs2;
   logic [N_GPIO-1:0] w_dec_gwe;
   logic [GSEL_W-1:0] w_dec_gsel;
   logic              w_dec_ill;

   mstate_e           r_state;
   mstate_e           w_state_n;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_n;

   ex_ctrl_t          r_ex;
   logic              r_ex_valid;
   logic              r_fwd_a;
   logic              r_fwd_b;
   logic [N_GPIO-1:0] r_ex_gwe;
   logic [GSEL_W-1:0] r_ex_gsel;
   wb_ctrl_t          r_wb;
   logic              r_wb_valid;
   logic [N_GPIO-1:0] r_wb_gwe;
   logic [GSEL_W-1:0] r_wb_gsel;
   logic              r_illegal;

   logic              w_stall;
   logic              w_accept;
   logic              w_take;
   logic              w_load_mul;
   logic              w_ex_wr;
   logic              w_fa;
   logic              w_fb;

   ctrl_decode #(
      .N_GPIO        (N_GPIO),
      .CSR_BASE      (CSR_BASE),
      .GPIO_OUT_MASK (GPIO_OUT_MASK),
      .GSEL_W        (GSEL_W)
   ) u_dec (
      .i_inst     (inst),
      .o_ex       (w_dec),
      .o_use_rs2  (w_dec_rs2),
      .o_gpio_we  (w_dec_gwe),
      .o_gpio_sel (w_dec_gsel),
      .o_illegal  (w_dec_ill)
   );

   // The mul holds EX while the counter is nonzero; at zero it advances
   assign w_stall    = (r_state == S_MSTALL) && (r_cnt != '0);
   assign inst_ready = !w_stall;
   assign w_accept   = inst_valid && inst_ready;
   assign w_take     = w_accept && !w_dec_ill;
   assign w_load_mul = w_take && is_mul_op(w_dec.aluop) &&
                       (MUL_LATENCY > 1);

   assign w_ex_wr = r_ex_valid && r_ex.wb.regwrite &&
                    (r_ex.wb.rd != 5'd0);
   assign w_fa    = w_ex_wr && (w_dec.rs1 == r_ex.wb.rd);
   assign w_fb    = w_ex_wr && w_dec_rs2 && (w_dec.rs2 == r_ex.wb.rd);

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      unique case (r_state)
         S_RUN:    w_state_n = S_RUN;
         S_MSTALL: begin
            if (r_cnt == '0)
               w_state_n = S_RUN;
            else
               w_cnt_n = r_cnt - 1'b1;
         end
      endcase
      if (w_load_mul) begin
         w_state_n = S_MSTALL;
         w_cnt_n   = CNT_W'(MUL_LATENCY - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex       <= '0;
         r_ex_valid <= 1'b0;
         r_fwd_a    <= 1'b0;
         r_fwd_b    <= 1'b0;
         r_ex_gwe   <= '0;
         r_ex_gsel  <= '0;
      end else if (w_stall) begin
         // producer has reached the regfile after the first stall edge
         r_fwd_a <= 1'b0;
         r_fwd_b <= 1'b0;
      end else if (w_take) begin
         r_ex       <= w_dec;
         r_ex_valid <= 1'b1;
         r_fwd_a    <= w_fa;
         r_fwd_b    <= w_fb;
         r_ex_gwe   <= w_dec_gwe;
         r_ex_gsel  <= w_dec_gsel;
      end else begin
         r_ex       <= '0;
         r_ex_valid <= 1'b0;
         r_fwd_a    <= 1'b0;
         r_fwd_b    <= 1'b0;
         r_ex_gwe   <= '0;
         r_ex_gsel  <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb       <= '0;
         r_wb_valid <= 1'b0;
         r_wb_gwe   <= '0;
         r_wb_gsel  <= '0;
      end else if (w_stall) begin
         r_wb       <= '0;
         r_wb_valid <= 1'b0;
         r_wb_gwe   <= '0;
         r_wb_gsel  <= '0;
      end else begin
         r_wb       <= r_ex.wb;
         r_wb_valid <= r_ex_valid;
         r_wb_gwe   <= r_ex_gwe;
         r_wb_gsel  <= r_ex_gsel;
      end
   end

   // set wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_illegal <= 1'b0;
      else if (w_accept && w_dec_ill)
         r_illegal <= 1'b1;
      else if (illegal_clr)
         r_illegal <= 1'b0;
   end

   assign ex_valid    = r_ex_valid;
   assign ex_aluop    = r_ex.aluop;
   assign ex_alusrc   = r_ex.alusrc;
   assign ex_imm      = r_ex.imm;
   assign ex_rs1      = r_ex.rs1;
   assign ex_rs2      = r_ex.rs2;
   assign ex_fwd_a    = r_fwd_a;
   assign ex_fwd_b    = r_fwd_b;
   assign wb_valid    = r_wb_valid;
   assign wb_regwrite = r_wb.regwrite;
   assign wb_rd       = r_wb.rd;
   assign wb_regsel   = r_wb.regsel;
   assign wb_gpio_we  = r_wb_gwe;
   assign wb_gpio_sel = r_wb_gsel;
   assign wb_imm      = r_wb.imm;
   assign illegal     = r_illegal;

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered, parametrised successor to the combinational RV32 control unit.
- Decodes one 32-bit instruction per accepted cycle into an EX-stage control register and a WB-stage control register (3-stage fetch/EX/WB CPU).
- Adds WB-to-EX forwarding flags, a multi-cycle multiply stall and N memory-mapped GPIO CSR channels.
- Adds sticky illegal-instruction detection.

Parameters:
- N_GPIO, 2: number of CSR-mapped GPIO channels.
- CSR_BASE, 12'hF00: CSR address of channel 0; channel i is at CSR_BASE+i.
- GPIO_OUT_MASK, 2'b01: bit i = 1 makes channel i an output (write-only, e.g. HEX); 0 makes it an input (read-only, e.g. SW).
- MUL_LATENCY, 1: EX cycles for mul/mulh/mulhu; range 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- inst_valid  in  1  inst is valid this cycle.
- inst  in  32  raw instruction.
- inst_ready  out  1  instruction is accepted when inst_valid && inst_ready.
- ex_valid  out  1  EX register holds a real instruction.
- ex_aluop  out  4  ALU operation.
- ex_alusrc  out  1  0 = rs2, 1 = ex_imm.
- ex_imm  out  32  extended immediate.
- ex_rs1, ex_rs2  out  5 each  source register indices.
- ex_fwd_a, ex_fwd_b  out  1 each  take operand from WB result instead of the regfile.
- wb_valid  out  1  WB register holds a real instruction.
- wb_regwrite  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_regsel  out  2  00 = GPIO input, 01 = U-immediate, 10 = ALU result.
- wb_gpio_we  out  N_GPIO  one-hot output-channel write strobe.
- wb_gpio_sel  out  $clog2(N_GPIO) (min 1)  channel index.
- wb_imm  out  32  U-immediate for lui.
- illegal  out  1  sticky illegal-instruction flag.
- illegal_clr  in  1  clears illegal.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0 except inst_ready = 1; stall counter = 0.
- aluop encoding:
  - and 0000, or 0001, xor 0010, add 0011, sub 0100.
  - mul 0101, mulh 0110, mulhu 0111.
  - sll 1000, srl 1001, sra 1010.
  - slt 1100, sltu 1101.
  - addi, andi, xori, slli, srli and srai reuse the R-type codes.
- Decode:
  - R-type: opcode 0x33; keyed on funct7 ∈ {0x00, 0x20, 0x01} and funct3; alusrc = 0.
  - I-type: opcode 0x13; imm = sign-extended inst[31:20]; alusrc = 1.
  - I-type shifts: imm = zero-extended shamt inst[24:20]; srai requires funct7 = 0x20, slli/srli require 0x00.
  - lui: opcode 0x37; imm = {inst[31:12], 12'b0}; regsel = 01; aluop = add; alusrc = 1.
  - csrrw: opcode 0x73, funct3 001, csr = inst[31:20] in [CSR_BASE, CSR_BASE+N_GPIO).
    - Output channel: gpio_we[i] = 1, regwrite = 0.
    - Input channel: regwrite = 1, regsel = 00, gpio_we = 0.
  - Everything else, including csrrw to an unmapped CSR, is illegal.
- Accept (inst_valid && inst_ready): EX register loads the decoded fields next edge.
- No accept: EX loads a bubble (ex_valid = 0) unless stalled.
- EX to WB: WB loads the EX control every cycle EX is not stalled; during stall cycles WB loads a bubble.
- Latency: one instruction reaches EX one cycle after accept and WB one cycle later (when MUL_LATENCY = 1).
- Illegal instruction:
  - Accepted, but inserted as a bubble.
  - illegal is set next edge.
  - illegal_clr clears it; a simultaneous set and clear leaves it set.
- Forwarding:
  - ex_fwd_a is registered at accept: new rs1 == current ex_rd && ex_valid && ex regwrite && ex_rd != 0.
  - ex_fwd_b is the same with rs2; set only when the new instruction is R-type.
  - Both clear after the first stall cycle, because the producer has already written the register file.
- Multiply stall (MUL_LATENCY > 1):
  - Two states, RUN and MSTALL.
  - Entering EX with a mul-class op loads counter = MUL_LATENCY-1 and the state goes to MSTALL.
  - In MSTALL: inst_ready = 0, EX holds, counter decrements each cycle.
  - Leave MSTALL at counter == 0; EX advances that edge.
  - inst_ready is combinational from the state and the EX op, so inst_ready is low in the cycle the mul first sits in EX.
  - Back-to-back muls each stall independently.
- x0: rd = 0 forces regwrite = 0 (GPIO strobe unaffected).
- Reset mid-stall: immediate return to RUN, all pipeline registers cleared, no WB write emitted.

Decomposition:
- Package ctrl_pkg holds:
  - aluop localparams.
  - opcode constants (0x33, 0x13, 0x37, 0x73).
  - regsel enum.
  - A packed struct for the EX control fields.
  - A packed struct for the WB control fields.
- Sub-module ctrl_decode: purely combinational, inst → EX struct + illegal.
- control_unit_pipe holds the registers, stall FSM, forwarding compare and sticky flag.

Test Plan:
- add x3,x1,x2 accepted at cycle 0:
  - cycle 1: ex_valid = 1, ex_aluop = 0011, ex_alusrc = 0.
  - cycle 2: wb_regwrite = 1, wb_rd = 3, wb_regsel = 10.
- addi x5,x0,1 then add x6,x5,x5 back-to-back → second instruction in EX has ex_fwd_a = ex_fwd_b = 1; repeated with x0 as the destination → both 0.
- MUL_LATENCY = 3, mul x7,x1,x2 followed by add x8,x7,x1:
  - inst_ready low for 2 cycles.
  - WB shows 2 bubbles, then the mul.
  - the add then enters EX with ex_fwd_a = 1.
- csrrw x0,0xF00,x4 (channel 0 is an output) → wb_gpio_we = 01, wb_regwrite = 0.
- csrrw x9,0xF01,x0 (input) → wb_regwrite = 1, wb_regsel = 00, wb_gpio_sel = 1.
- inst = 32'h0000007F:
  - illegal = 1 next cycle, ex_valid = 0.
  - Pulse illegal_clr together with a second illegal instruction → illegal stays 1.
  - illegal_clr alone → 0.
- Assert rst_n low during the second cycle of a mul stall → all outputs 0 and inst_ready = 1 immediately (asynchronous); after release, a new add decodes normally.
